// File: rtl/move_buffer_pkg.sv
// Shared move-record definitions and SPI message header codes for the
// decoder -> move_buffer -> timing engine path.
package move_buffer_pkg;

  localparam int DEF_DUR_W = 64;
  localparam int DEF_INC_W = 64;

  typedef struct packed {
    logic                 dir;
    logic [DEF_DUR_W-1:0] duration;
    logic [DEF_INC_W-1:0] increment;
    logic [DEF_INC_W-1:0] incincr;
  } move_record_t;

  localparam logic [7:0] MSG_MOVE      = 8'h01;
  localparam logic [7:0] MSG_CLKDIV    = 8'h03;
  localparam logic [7:0] MSG_MICROSTEP = 8'h04;

endpackage

// File: rtl/move_buffer_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module move_buffer_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/move_buffer.sv
// FWFT move-record FIFO between the SPI decoder and the stepper timing engine.
// Optional MOVE_BUFFER_WATERMARK_EN adds a registered almost_empty output.
module move_buffer
  import move_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DUR_W = DEF_DUR_W,
  parameter int INC_W = DEF_INC_W
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       wr_dir,
  input  logic [DUR_W-1:0]           wr_duration,
  input  logic [INC_W-1:0]           wr_increment,
  input  logic [INC_W-1:0]           wr_incincr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_dir,
  output logic [DUR_W-1:0]           rd_duration,
  output logic [INC_W-1:0]           rd_increment,
  output logic [INC_W-1:0]           rd_incincr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef MOVE_BUFFER_WATERMARK_EN
  ,
  output logic                       almost_empty
`endif
);

  localparam int REC_W = 1 + DUR_W + 2 * INC_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] head;
  logic [CW-1:0]    count_next;
  logic             full;
  logic             push;
  logic             pop;

  assign full     = (count == FULL_COUNT);
  assign wr_ready = !full;
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign wr_rec   = {wr_dir, wr_duration, wr_increment, wr_incincr};

  move_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (push && !clear),
    .wr_addr (wr_ptr),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Storage is not reset, so the head is masked to zero while empty.
  assign {rd_dir, rd_duration, rd_increment, rd_incincr} = rd_valid ? head : '0;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      if (wr_valid && full) overflow <= 1'b1;
    end
  end

`ifdef MOVE_BUFFER_WATERMARK_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)      almost_empty <= 1'b1;
    else if (clear) almost_empty <= 1'b1;
    else            almost_empty <= (count_next <= CW'(1));
  end
`endif

endmodule

// File: tb/tb_move_buffer.sv
// Self-checking bench for move_buffer: table-driven fill/drain plus scoreboard.
module tb_move_buffer;
  import move_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic         CLK = 1'b0;
  logic         reset;
  logic         clear;
  logic         wr_valid;
  logic         rd_ready;
  move_record_t wr_rec;
  logic         wr_ready;
  logic         rd_valid;
  logic         rd_dir;
  logic [63:0]  rd_duration;
  logic [63:0]  rd_increment;
  logic [63:0]  rd_incincr;
  logic [2:0]   count;
  logic         overflow;
`ifdef MOVE_BUFFER_WATERMARK_EN
  logic         almost_empty;
`endif

  move_buffer #(.DEPTH(DEPTH), .DUR_W(64), .INC_W(64)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .clear        (clear),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_dir       (wr_rec.dir),
    .wr_duration  (wr_rec.duration),
    .wr_increment (wr_rec.increment),
    .wr_incincr   (wr_rec.incincr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_dir       (rd_dir),
    .rd_duration  (rd_duration),
    .rd_increment (rd_increment),
    .rd_incincr   (rd_incincr),
    .count        (count),
    .overflow     (overflow)
`ifdef MOVE_BUFFER_WATERMARK_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wv;
    logic       rr;
    logic [2:0] exp_count;
    logic       exp_wr_ready;
    logic       exp_ovf;
  } vec_t;

  vec_t         tbl[9];
  move_record_t sb[$];
  logic         m_ovf;
  int           total;
  int           bad;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic move_record_t mk(input int i);
    move_record_t r;
    r.dir       = i[0];
    r.duration  = {32'hD0000000 | 32'(i), $urandom};
    r.increment = {$urandom, $urandom};
    r.incincr   = {$urandom, 24'h0, 8'(i)};
    return r;
  endfunction

  // Check current outputs against the model, take one clock, update the model.
  task automatic tick();
    logic p, q;
    chk("count", 200'(count), 200'(sb.size()));
    chk("rd_valid", 200'(rd_valid), 200'(sb.size() != 0));
    chk("wr_ready", 200'(wr_ready), 200'(sb.size() < DEPTH));
    chk("overflow", 200'(overflow), 200'(m_ovf));
    if (sb.size() != 0)
      chk("head", 200'({rd_dir, rd_duration, rd_increment, rd_incincr}), 200'(sb[0]));
`ifdef MOVE_BUFFER_WATERMARK_EN
    chk("almost_empty", 200'(almost_empty), 200'(sb.size() <= 1));
`endif
    @(posedge CLK);
    #1;
    if (clear) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      p = wr_valid && (sb.size() < DEPTH);
      q = rd_ready && (sb.size() != 0);
      if (wr_valid && sb.size() == DEPTH) m_ovf = 1'b1;
      if (q) void'(sb.pop_front());
      if (p) sb.push_back(wr_rec);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_ovf = 1'b0;
    reset = 1'b1;
    clear = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_rec = '0;

    // reset values
    #3;
    chk("rst_count", 200'(count), 200'(0));
    chk("rst_rd_valid", 200'(rd_valid), 200'(0));
    chk("rst_wr_ready", 200'(wr_ready), 200'(1));
    chk("rst_overflow", 200'(overflow), 200'(0));
    chk("rst_rd_data", 200'({rd_dir, rd_duration, rd_increment, rd_incincr}), 200'(0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;

    // single push: visible one cycle later, bit-exact
    wr_rec.dir = 1'b1;
    wr_rec.duration = 64'h4FFFFF;
    wr_rec.increment = 64'd100000000000;
    wr_rec.incincr = 64'd1000000000;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t1_rd_valid", 200'(rd_valid), 200'(1));
    chk("t1_count", 200'(count), 200'(1));
    chk("t1_dir", 200'(rd_dir), 200'(1));
    chk("t1_duration", 200'(rd_duration), 200'(64'h4FFFFF));
    chk("t1_increment", 200'(rd_increment), 200'(64'd100000000000));
    chk("t1_incincr", 200'(rd_incincr), 200'(64'd1000000000));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();

    // fill to full, overflow on 5th push, drain in order
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 1'b0, 3'(i + 1), (i < 3), 1'b0};
    tbl[4] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) tbl[5 + i] = '{1'b0, 1'b1, 3'(3 - i), 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      wr_valid = tbl[i].wv;
      rd_ready = tbl[i].rr;
      wr_rec = mk(i + 10);
      tick();
      chk("tbl_count", 200'(count), 200'(tbl[i].exp_count));
      chk("tbl_wr_ready", 200'(wr_ready), 200'(tbl[i].exp_wr_ready));
      chk("tbl_overflow", 200'(overflow), 200'(tbl[i].exp_ovf));
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();

    // steady push+pop at count 2 across pointer wrap
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_rec = mk(20 + i);
      tick();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_rec = mk(30 + i);
      tick();
      chk("t3_count", 200'(count), 200'(2));
    end
    wr_valid = 1'b0;
    tick();
    tick();
    rd_ready = 1'b0;
    tick();

    // full with simultaneous push and pop: push refused
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_rec = mk(50 + i);
      tick();
    end
    rd_ready = 1'b1;
    wr_rec = mk(60);
    tick();
    chk("t4_count", 200'(count), 200'(3));
    chk("t4_overflow", 200'(overflow), 200'(1));

    // clear beats a concurrent push
    rd_ready = 1'b0;
    clear = 1'b1;
    wr_rec = mk(70);
    tick();
    clear = 1'b0;
    wr_valid = 1'b0;
    chk("t5_count", 200'(count), 200'(0));
    chk("t5_overflow", 200'(overflow), 200'(0));
    chk("t5_rd_valid", 200'(rd_valid), 200'(0));
    tick();

    // asynchronous reset between edges
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_rec = mk(80 + i);
      tick();
    end
    wr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rd_valid", 200'(rd_valid), 200'(0));
    chk("t6_count", 200'(count), 200'(0));
    chk("t6_overflow", 200'(overflow), 200'(0));
    chk("t6_rd_duration", 200'(rd_duration), 200'(0));
`ifdef MOVE_BUFFER_WATERMARK_EN
    chk("t6_almost_empty", 200'(almost_empty), 200'(1));
`endif
    sb.delete();
    m_ovf = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
